// File: rtl/floating_point_max_of_n_if.sv
// rtl/floating_point_max_of_n_if.sv - stream and result bundle for floating_point_max_of_n
interface floating_point_max_of_n_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in1;
    logic [DATA_WIDTH-1:0] in2;
    logic [DATA_WIDTH-1:0] in3;
    logic [DATA_WIDTH-1:0] in4;
    logic                  in_ready;
    logic                  busy;
    logic [DATA_WIDTH-1:0] max_input;
    logic                  softmax_enable;

    modport master (
        output start, in_valid, in1, in2, in3, in4,
        input  in_ready, busy, max_input, softmax_enable
    );

    modport slave (
        input  start, in_valid, in1, in2, in3, in4,
        output in_ready, busy, max_input, softmax_enable
    );
endinterface

// File: rtl/floating_point_max_of_n.sv
// rtl/floating_point_max_of_n.sv - streaming sign-aware max reduction feeding the softmax exp stage
module floating_point_max_of_n #(
    parameter int ARITH_TYPE = 0,
    parameter int DATA_WIDTH = 32,
    parameter int E          = 8,
    parameter int M          = 23,
    parameter int N_ELEMS    = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    floating_point_max_of_n_if.slave bus
);
    localparam int BEATS    = (N_ELEMS + 3) / 4;
    localparam int CW       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SIGN_BIT = (ARITH_TYPE == 0) ? (E + M) : (DATA_WIDTH - 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [DATA_WIDTH-1:0] MSB = DATA_WIDTH'(1) << SIGN_BIT;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
    logic                  first_q, first_d;
    logic [DATA_WIDTH-1:0] running_q, running_d;
    logic [DATA_WIDTH-1:0] max_q, max_d;

    logic [DATA_WIDTH-1:0] lane [4];
    logic [3:0]            lane_ok;
    logic [DATA_WIDTH-1:0] beat_max;
    logic [DATA_WIDTH-1:0] new_max;

    // Unsigned ordering key: FP folds sign-magnitude onto a monotone line,
    // fixed point just flips the sign bit to turn signed into unsigned order.
    function automatic logic [DATA_WIDTH-1:0] key_f(input logic [DATA_WIDTH-1:0] x);
        if (ARITH_TYPE == 0)
            key_f = x[DATA_WIDTH-1] ? ~x : (x | MSB);
        else
            key_f = x ^ MSB;
    endfunction

    assign lane[0] = bus.in1;
    assign lane[1] = bus.in2;
    assign lane[2] = bus.in3;
    assign lane[3] = bus.in4;

    // Lanes past the end of the vector on the last beat are masked out
    always_comb begin
        lane_ok = '0;
        for (int k = 0; k < 4; k++)
            lane_ok[k] = ((int'(beat_cnt_q) * 4) + k) < N_ELEMS;
    end

    // Beat maximum; strict greater-than keeps the lowest index on ties (lane 0 always valid)
    always_comb begin
        beat_max = lane[0];
        for (int k = 1; k < 4; k++)
            if (lane_ok[k] && (key_f(lane[k]) > key_f(beat_max)))
                beat_max = lane[k];
    end

    // Running value holds earlier indices, so it wins ties against the new beat
    assign new_max = (first_q || (key_f(beat_max) > key_f(running_q))) ? beat_max : running_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt_q <= '0;
            first_q    <= 1'b0;
            running_q  <= '0;
            max_q      <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            first_q    <= first_d;
            running_q  <= running_d;
            max_q      <= max_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        first_d    = first_q;
        running_d  = running_q;
        max_d      = max_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = ACCUM;
                    beat_cnt_d = '0;
                    first_d    = 1'b1;
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    first_d   = 1'b0;
                    running_d = new_max;
                    if (beat_cnt_q == LAST_BEAT) begin
                        max_d      = new_max;
                        state_d    = DONE;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        bus.in_ready       = (state_q == ACCUM);
        bus.busy           = (state_q == ACCUM) || (state_q == DONE);
        bus.softmax_enable = (state_q == DONE);
        bus.max_input      = max_q;
    end
endmodule

// File: tb/tb_floating_point_max_of_n.sv
// tb/tb_floating_point_max_of_n.sv - scoreboard bench for floating_point_max_of_n
module tb_floating_point_max_of_n;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] exp_fp[$];
    logic [15:0] exp_fx[$];
    logic        prev_fp_en = 1'b0;
    logic        prev_fx_en = 1'b0;

    always #5 clk = ~clk;

    floating_point_max_of_n_if #(.DATA_WIDTH(32)) fp_if ();
    floating_point_max_of_n_if #(.DATA_WIDTH(16)) fx_if ();

    floating_point_max_of_n #(
        .ARITH_TYPE(0), .DATA_WIDTH(32), .E(8), .M(23), .N_ELEMS(10)
    ) u_fp (.clk(clk), .reset(reset), .bus(fp_if.slave));

    floating_point_max_of_n #(
        .ARITH_TYPE(1), .DATA_WIDTH(16), .E(8), .M(23), .N_ELEMS(4)
    ) u_fx (.clk(clk), .reset(reset), .bus(fx_if.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every softmax_enable pulse pops one expected max and is one cycle wide
    always @(negedge clk) begin
        if (!reset && fp_if.softmax_enable) begin
            if (prev_fp_en) check("fp_pulse_width", 32'd2, 32'd1);
            if (exp_fp.size() == 0) check("fp_unexpected_pulse", 32'd1, 32'd0);
            else check("fp_max_input", fp_if.max_input, exp_fp.pop_front());
        end
        prev_fp_en = fp_if.softmax_enable;
    end

    always @(negedge clk) begin
        if (!reset && fx_if.softmax_enable) begin
            if (prev_fx_en) check("fx_pulse_width", 32'd2, 32'd1);
            if (exp_fx.size() == 0) check("fx_unexpected_pulse", 32'd1, 32'd0);
            else check("fx_max_input", {16'h0, fx_if.max_input}, {16'h0, exp_fx.pop_front()});
        end
        prev_fx_en = fx_if.softmax_enable;
    end

    task automatic fp_start();
        fp_if.start = 1'b1;
        @(negedge clk);
        fp_if.start = 1'b0;
    endtask

    task automatic fp_beat(input logic [31:0] a, b, c, d);
        check("fp_ready_in_accum", {30'h0, fp_if.in_ready, fp_if.busy}, 32'd3);
        fp_if.in_valid = 1'b1;
        fp_if.in1 = a; fp_if.in2 = b; fp_if.in3 = c; fp_if.in4 = d;
        @(negedge clk);
        fp_if.in_valid = 1'b0;
    endtask

    task automatic fp_gap(input int n);
        repeat (n) begin
            check("fp_busy_in_gap", {30'h0, fp_if.in_ready, fp_if.busy}, 32'd3);
            @(negedge clk);
        end
    endtask

    // Called right after the last beat: must be in DONE with the pulse up
    task automatic fp_expect_done(input logic [31:0] exp);
        check("fp_pulse_timing", {31'h0, fp_if.softmax_enable}, 32'd1);
        check("fp_done_max", fp_if.max_input, exp);
        check("fp_done_flags", {30'h0, fp_if.in_ready, fp_if.busy}, 32'd1);
        @(negedge clk);
        check("fp_idle_flags", {29'h0, fp_if.softmax_enable, fp_if.in_ready, fp_if.busy}, 32'd0);
    endtask

    task automatic fx_vec(input logic [15:0] a, b, c, d, input logic [15:0] exp);
        exp_fx.push_back(exp);
        fx_if.start = 1'b1;
        @(negedge clk);
        fx_if.start = 1'b0;
        fx_if.in_valid = 1'b1;
        fx_if.in1 = a; fx_if.in2 = b; fx_if.in3 = c; fx_if.in4 = d;
        @(negedge clk);
        fx_if.in_valid = 1'b0;
        check("fx_pulse_timing", {31'h0, fx_if.softmax_enable}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        fp_if.start = 0; fp_if.in_valid = 0;
        fp_if.in1 = 0; fp_if.in2 = 0; fp_if.in3 = 0; fp_if.in4 = 0;
        fx_if.start = 0; fx_if.in_valid = 0;
        fx_if.in1 = 0; fx_if.in2 = 0; fx_if.in3 = 0; fx_if.in4 = 0;
        repeat (2) @(negedge clk);
        check("reset_fp_flags", {29'h0, fp_if.softmax_enable, fp_if.in_ready, fp_if.busy}, 32'd0);
        check("reset_fp_max", fp_if.max_input, 32'h0);
        check("reset_fx_max", {16'h0, fx_if.max_input}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Mixed-sign vector; last beat's lanes 2-3 hold huge values that must be ignored
        exp_fp.push_back(32'h40A00000);
        fp_start();
        fp_beat(32'h3F800000, 32'h40000000, 32'hC0400000, 32'h3F000000);
        fp_beat(32'h40A00000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        fp_beat(32'h40800000, 32'hBF800000, 32'h7F000000, 32'h7F000000);
        fp_expect_done(32'h40A00000);

        // All negatives
        exp_fp.push_back(32'hBF000000);
        fp_start();
        fp_beat(32'hC0000000, 32'hBF000000, 32'hC1000000, 32'hC0800000);
        fp_beat(32'hC1200000, 32'hC1100000, 32'hC0A00000, 32'hC0E00000);
        fp_beat(32'hC1800000, 32'hC1000000, 32'h7F800000, 32'h7F800000);
        fp_expect_done(32'hBF000000);

        // -0 versus +0
        exp_fp.push_back(32'h00000000);
        fp_start();
        fp_beat(32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000);
        fp_beat(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);
        fp_beat(32'h80000000, 32'h80000000, 32'h7F000000, 32'h7F000000);
        fp_expect_done(32'h00000000);

        // in_valid in IDLE is ignored, then gaps between beats
        fp_if.in_valid = 1'b1;
        fp_if.in1 = 32'h7F000000; fp_if.in2 = 32'h7F000000;
        fp_if.in3 = 32'h7F000000; fp_if.in4 = 32'h7F000000;
        repeat (3) @(negedge clk);
        check("idle_beats_ignored", {30'h0, fp_if.in_ready, fp_if.busy}, 32'd0);
        fp_if.in_valid = 1'b0;
        exp_fp.push_back(32'h40E00000);
        fp_start();
        fp_beat(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
        fp_gap(2);
        fp_beat(32'h40C00000, 32'h40A00000, 32'h3F000000, 32'hC0000000);
        fp_gap(2);
        fp_beat(32'h40E00000, 32'h3F800000, 32'h7F000000, 32'h7F000000);
        fp_expect_done(32'h40E00000);

        // start held through ACCUM and DONE is ignored
        exp_fp.push_back(32'h40400000);
        fp_start();
        fp_if.start = 1'b1;
        fp_beat(32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        check("hold_during_accum", fp_if.max_input, 32'h40E00000);
        fp_beat(32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        fp_beat(32'h3F800000, 32'h3F800000, 32'h7F000000, 32'h7F000000);
        check("start_in_done_pulse", {31'h0, fp_if.softmax_enable}, 32'd1);
        @(negedge clk);
        fp_if.start = 1'b0;
        check("start_in_done_ignored", {30'h0, fp_if.in_ready, fp_if.busy}, 32'd0);
        @(negedge clk);
        check("still_idle", {30'h0, fp_if.in_ready, fp_if.busy}, 32'd0);
        check("max_held_idle", fp_if.max_input, 32'h40400000);

        // Fixed-point instance, one beat per vector
        fx_vec(16'hFFF0, 16'h0010, 16'h8000, 16'h0010, 16'h0010);
        fx_vec(16'h8000, 16'h8001, 16'hFFFF, 16'h8000, 16'hFFFF);
        fx_vec(16'h7FFF, 16'h0000, 16'h8000, 16'h7FFF, 16'h7FFF);

        // Reset mid-vector aborts with no pulse, then a clean vector
        fp_start();
        fp_beat(32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        fp_beat(32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        check("max_held_accum", fp_if.max_input, 32'h40400000);
        #2 reset = 1'b1;
        #1;
        check("async_reset_flags", {29'h0, fp_if.softmax_enable, fp_if.in_ready, fp_if.busy}, 32'd0);
        check("async_reset_max", fp_if.max_input, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_fp.push_back(32'h3F400000);
        fp_start();
        fp_beat(32'hBF800000, 32'hC0000000, 32'h3F000000, 32'h3E800000);
        fp_beat(32'h3E000000, 32'h3F000000, 32'h3F400000, 32'h3F000000);
        fp_beat(32'h3F400000, 32'h3F000000, 32'h7F000000, 32'h7F000000);
        fp_expect_done(32'h3F400000);

        repeat (2) @(negedge clk);
        check("fp_scoreboard_drained", exp_fp.size(), 32'd0);
        check("fx_scoreboard_drained", exp_fx.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/floating_point_max_of_n.md
Name: floating_point_max_of_n

Overview:
- Upstream stage of the softmax exp-input calculator.
- Receives the N softmax inputs as a stream, 4 lanes per beat, and reduces them to the single maximum (max_input).
- Pulses softmax_enable for one cycle when max_input is valid. The downstream stage uses these to form max − x_i.
- Comparison is sign-aware for both floating-point and signed fixed-point data.

Parameters:
ARITH_TYPE, 0, 0 = sign/exponent/mantissa floating point (E,M fields); 1 = two's-complement fixed point
DATA_WIDTH, 32, width of each element
E, 8, exponent width (ARITH_TYPE=0 only)
M, 23, mantissa width (ARITH_TYPE=0 only); DATA_WIDTH = 1+E+M
N_ELEMS, 10, number of elements per softmax vector, range 1..64
BEATS (localparam), ceil(N_ELEMS/4), number of input beats per vector

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  pulse: begin a new reduction (accepted in IDLE only)
in_valid  in  1  in1..in4 carry a beat this cycle
in1  in  DATA_WIDTH  lane 0, element index 4*beat+0
in2  in  DATA_WIDTH  lane 1, element index 4*beat+1
in3  in  DATA_WIDTH  lane 2, element index 4*beat+2
in4  in  DATA_WIDTH  lane 3, element index 4*beat+3
in_ready  out  1  high in ACCUM; a beat is accepted when in_valid && in_ready
busy  out  1  high in ACCUM or DONE
max_input  out  DATA_WIDTH  registered maximum of the last completed vector
softmax_enable  out  1  one-cycle pulse; max_input valid on and after this cycle

Behaviour:
- Reset (async, active-high): state=IDLE, beat_cnt=0, running max=0, max_input=0, softmax_enable=0, in_ready=0, busy=0. Reset mid-vector aborts it; no pulse is issued.
- States (Moore outputs): IDLE, ACCUM, DONE.
- IDLE
  - start=1 -> ACCUM; beat_cnt<=0; first_beat flag<=1.
  - in_valid is ignored.
- ACCUM
  - in_ready=1.
  - On an accepted beat: lane k is valid iff 4*beat_cnt+k < N_ELEMS; invalid lanes are excluded from the compare.
  - beat_max = max of the valid lanes.
  - If first_beat, running <= beat_max; else running <= max(running, beat_max). first_beat<=0.
  - If beat_cnt==BEATS-1: max_input <= the same final value, state -> DONE, beat_cnt <= 0. Otherwise beat_cnt <= beat_cnt+1.
  - No accepted beat: hold all state. start is ignored.
- DONE
  - softmax_enable=1 for exactly one cycle, then -> IDLE. start is ignored.
- Latency: last beat accepted at cycle t -> max_input updated at edge t+1 -> softmax_enable high during cycle t+1.
  - Minimum vector time: 1 (start) + BEATS + 1 cycles. For N_ELEMS=10: start@0, beats@1..3, pulse@4, next start accepted @5.
- max_input holds between completions; it changes only on a final accepted beat.
- Compare, ARITH_TYPE=0: map each value to an unsigned key.
  - sign=0: key = x with MSB set.
  - sign=1: key = bitwise NOT of x.
  - Compare keys unsigned, so −0 < +0, and infinities order naturally. NaN is unsupported; result undefined.
- Compare, ARITH_TYPE=1: signed compare on DATA_WIDTH bits.
- Ties: the lower element index wins. Output is the original bit pattern, never the key.
- N_ELEMS a multiple of 4: all lanes are valid on the last beat.
- N_ELEMS<=4: a single beat completes the vector.

Test Plan:
- N=10, FP. Beats (1.0,2.0,−3.0,0.5)=(3F800000,40000000,C0400000,3F000000), (5.0=40A00000,1.0,1.0,1.0), then (4.0=40800000, −1.0=BF800000, 7F000000, 7F000000) -> max_input=40A00000. Lanes 2–3 of beat 3 are ignored. softmax_enable pulses exactly 1 cycle after the 3rd accepted beat.
- All negatives (−2.0=C0000000, −0.5=BF000000, −8.0=C1000000, …) -> max_input=BF000000. Separately, −0 vs +0 (80000000, 00000000) -> 00000000.
- Gaps: in_valid low 2 cycles between beats, and in_valid high while in IDLE -> the gaps do not change the result; IDLE beats are not counted; busy stays high throughout ACCUM.
- start asserted during ACCUM and DONE -> ignored; the next vector starts only after returning to IDLE, and max_input holds the previous value until that vector completes.
- reset pulsed after beat 2 -> all outputs 0 asynchronously; no softmax_enable. A new start plus 3 beats yields the correct max.
- ARITH_TYPE=1, DATA_WIDTH=16, N=4. Beat (FFF0, 0010, 8000, 0010) -> max_input=0010, taken from lane 1 (tie: lower index).
